// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: symbol-rate burst scheduler for the 16-QAM modulator path.
// A burst is an alternating 0/F preamble, then payload symbols pulled from a
// valid/ready source, then a muted guard interval. One symbol index is issued
// per SPS clocks together with a first-clock strobe and a mute enable.
// Optional build macro TX_PILOT_EN inserts a 4'h5 pilot slot after every
// PILOT_INTERVAL payload data slots, never after the final one.
module tx_frame_sequencer #(
    parameter int SPS            = 8,
    parameter int PREAMBLE_LEN   = 16,
    parameter int PAYLOAD_LEN    = 64,
    parameter int GUARD_LEN      = 8,
    parameter int PILOT_INTERVAL = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic       CONTINUOUS,
    input  logic [3:0] DATA_IN,
    input  logic       DATA_VALID,
    output logic       DATA_READY,
    output logic [3:0] SYM_OUT,
    output logic       SYM_STB,
    output logic       SYM_EN,
    output logic       FRAME_ACTIVE,
    output logic       UNDERRUN
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GUARD} state_t;

    localparam int MAX_PG  = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int MAX_LEN = (PAYLOAD_LEN > MAX_PG) ? PAYLOAD_LEN : MAX_PG;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int SW      = $clog2(SPS);

    localparam logic [SW-1:0] SAMP_LAST = SW'(SPS - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] PAY_LAST  = CW'(PAYLOAD_LEN - 1);
    localparam logic [CW-1:0] GRD_LAST  = CW'(GUARD_LEN - 1);

    // Elaboration-time range check on the configuration; generates no logic.
    if (SPS < 2 || PREAMBLE_LEN < 1 || PAYLOAD_LEN < 1 || GUARD_LEN < 1 ||
        PILOT_INTERVAL < 1) begin : g_param_check
        $error("tx_frame_sequencer: parameter out of range");
    end

    state_t        state_q, state_d;
    logic [SW-1:0] samp_q, samp_d;   // sample index inside the current symbol slot
    logic [CW-1:0] cnt_q, cnt_d;     // symbol index within preamble/guard, data index in payload
    logic [3:0]    sym_q, sym_d;
    logic          und_q, und_d;
    logic          pend_q, pend_d;   // one-deep queued frame request

`ifdef TX_PILOT_EN
    localparam int             PW        = $clog2(PILOT_INTERVAL + 1);
    localparam logic [PW-1:0]  PIL_LAST  = PW'(PILOT_INTERVAL - 1);
    localparam logic [3:0]     PILOT_SYM = 4'h5;

    logic [PW-1:0] pcnt_q, pcnt_d;   // data slots since the last pilot
    logic          pilot_q, pilot_d; // current slot is a pilot
`endif

    logic       slot_end;
    logic       ready_w;
    logic [3:0] data_sym;

    assign slot_end = (state_q != IDLE) && (samp_q == SAMP_LAST);
    assign data_sym = DATA_VALID ? DATA_IN : 4'h0;

    // The source is offered a transfer on the last sample of a slot whose successor is a data slot.
`ifdef TX_PILOT_EN
    assign ready_w = slot_end &&
                     ((state_q == PREAMBLE && cnt_q == PRE_LAST) ||
                      (state_q == PAYLOAD && (pilot_q ||
                                              (cnt_q != PAY_LAST && pcnt_q != PIL_LAST))));
`else
    assign ready_w = slot_end &&
                     ((state_q == PREAMBLE && cnt_q == PRE_LAST) ||
                      (state_q == PAYLOAD && cnt_q != PAY_LAST));
`endif

    // State register: synchronous reset returns every register to its idle value.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            state_q <= IDLE;
            samp_q  <= '0;
            cnt_q   <= '0;
            sym_q   <= 4'h0;
            und_q   <= 1'b0;
            pend_q  <= 1'b0;
`ifdef TX_PILOT_EN
            pcnt_q  <= '0;
            pilot_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            und_q   <= und_d;
            pend_q  <= pend_d;
`ifdef TX_PILOT_EN
            pcnt_q  <= pcnt_d;
            pilot_q <= pilot_d;
`endif
        end
    end

    // Next-state logic: slot sequencing, symbol selection and handshake side effects.
    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path infers a latch.
        state_d = state_q;
        samp_d  = samp_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        und_d   = und_q;
        pend_d  = pend_q;
`ifdef TX_PILOT_EN
        pcnt_d  = pcnt_q;
        pilot_d = pilot_q;
`endif
        if (state_q != IDLE) begin
            samp_d = slot_end ? '0 : samp_q + SW'(1);
            if (START) pend_d = 1'b1;
        end
        // A starved handshake still consumes the slot (it carries 4'h0) and latches the flag.
        if (ready_w && !DATA_VALID) und_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = PREAMBLE;
                    samp_d  = '0;
                    cnt_d   = '0;
                    sym_d   = 4'h0;
                    und_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            PREAMBLE: begin
                if (slot_end) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = PAYLOAD;
                        cnt_d   = '0;
                        sym_d   = data_sym;
`ifdef TX_PILOT_EN
                        pcnt_d  = '0;
                        pilot_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        sym_d = cnt_q[0] ? 4'h0 : 4'hF;
                    end
                end
            end
            PAYLOAD: begin
                if (slot_end) begin
`ifdef TX_PILOT_EN
                    if (pilot_q) begin
                        pilot_d = 1'b0;
                        sym_d   = data_sym;
                    end else if (cnt_q == PAY_LAST) begin
                        state_d = GUARD;
                        cnt_d   = '0;
                        sym_d   = 4'h0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (pcnt_q == PIL_LAST) begin
                            pilot_d = 1'b1;
                            pcnt_d  = '0;
                            sym_d   = PILOT_SYM;
                        end else begin
                            pcnt_d = pcnt_q + PW'(1);
                            sym_d  = data_sym;
                        end
                    end
`else
                    if (cnt_q == PAY_LAST) begin
                        state_d = GUARD;
                        cnt_d   = '0;
                        sym_d   = 4'h0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        sym_d = data_sym;
                    end
`endif
                end
            end
            GUARD: begin
                if (slot_end) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == GRD_LAST) begin
                        cnt_d = '0;
                        sym_d = 4'h0;
                        // A START landing on this very cycle counts as a queued request.
                        if (CONTINUOUS || pend_q || START) begin
                            state_d = PREAMBLE;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: all outputs come from registers only.
    always_comb begin
        FRAME_ACTIVE = (state_q != IDLE);
        SYM_STB      = (state_q != IDLE) && (samp_q == '0);
        SYM_EN       = (state_q == PREAMBLE) || (state_q == PAYLOAD);
        DATA_READY   = ready_w;
        SYM_OUT      = sym_q;
        UNDERRUN     = und_q;
    end

endmodule

// File: doc/tx_frame_sequencer.md
Name: tx_frame_sequencer

Overview:
- Symbol-rate frame scheduler in front of the 16-QAM modulator/DAC path (50 MHz domain).
- Builds each burst as preamble, then payload pulled from a valid/ready source, then muted guard.
- Emits one 4-bit symbol index per SPS clocks, plus a one-cycle strobe and a mute enable.
- Modulator holds mid-scale while SYM_EN=0.

Parameters:
SPS, 8, clocks per symbol (>=2)
PREAMBLE_LEN, 16, preamble symbols per frame (>=1)
PAYLOAD_LEN, 64, data symbols per frame (>=1)
GUARD_LEN, 8, muted symbols after payload (>=1)
PILOT_INTERVAL, 16, data symbols between pilots (TX_PILOT_EN only, >=1)

Ports:
CLOCK_50 in 1 system clock, 50 MHz, single clock domain
RESET in 1 synchronous reset, active-high
START in 1 frame request, sampled every cycle
CONTINUOUS in 1 when 1, back-to-back frames without returning to IDLE
DATA_IN in 4 payload symbol index (Gray-mapped 16-QAM)
DATA_VALID in 1 source has a symbol
DATA_READY out 1 sequencer accepts DATA_IN this cycle
SYM_OUT out 4 current symbol index to modulator
SYM_STB out 1 one-cycle pulse on first clock of each symbol
SYM_EN out 1 0 = mute (IDLE and GUARD)
FRAME_ACTIVE out 1 1 in any state other than IDLE
UNDERRUN out 1 sticky payload-starvation flag

Behaviour:
- Reset values: all outputs 0. State IDLE, counters 0, pending-start flag 0.
- Reset mid-frame: next cycle is IDLE with all outputs 0. No partial symbol is held.
- States: IDLE, PREAMBLE, PAYLOAD, GUARD.
- Sample counter: counts 0..SPS-1 outside IDLE. Cleared to 0 on entry from IDLE. Wraps SPS-1 -> 0.
- Symbol slot boundary:
  - SYM_STB=1 and SYM_OUT loads the new symbol when the sample counter is 0.
  - SYM_OUT holds for SPS cycles.
  - SYM_STB is never high in IDLE.
- IDLE -> PREAMBLE on START=1.
  - Latency: the cycle after START, FRAME_ACTIVE=1, SYM_STB=1, SYM_EN=1, SYM_OUT=4'h0.
- PREAMBLE: symbol k = 4'h0 for even k, 4'hF for odd k. After PREAMBLE_LEN symbols -> PAYLOAD.
- Data handshake:
  - Transfer occurs when DATA_READY and DATA_VALID are both 1.
  - DATA_READY=1 only on sample counter SPS-1 of the slot that precedes a data slot, i.e. the last preamble symbol, or a payload symbol with data slots still remaining.
  - DATA_READY is decoded from registers only. There is no combinational path from any input.
  - Transferred DATA_IN becomes SYM_OUT at the next boundary.
- Underrun: if DATA_VALID=0 while DATA_READY=1:
  - the slot emits 4'h0;
  - the slot still counts toward PAYLOAD_LEN;
  - UNDERRUN sets to 1.
  - UNDERRUN clears only on RESET or when a new frame is launched from IDLE.
- PAYLOAD: after PAYLOAD_LEN data slots -> GUARD.
- GUARD:
  - GUARD_LEN symbols with SYM_EN=0 and SYM_OUT=4'h0.
  - SYM_STB keeps pulsing each slot.
  - FRAME_ACTIVE stays 1.
- End of GUARD:
  - If CONTINUOUS=1 or the pending-start flag is set -> PREAMBLE. The sample counter continues without a gap, and the pending flag clears.
  - Otherwise -> IDLE. FRAME_ACTIVE=0 the next cycle.
- START while FRAME_ACTIVE: sets the one-deep pending flag. Further STARTs are ignored until it clears.
- START and the GUARD final cycle coincide: treated as pending, so the next frame starts immediately.
- Symbol counters: width $clog2(max(PREAMBLE_LEN, PAYLOAD_LEN, GUARD_LEN)+1). Compare with ==; no overflow is permitted.
- Frame length without pilots: PREAMBLE_LEN + PAYLOAD_LEN + GUARD_LEN symbols.

Optional Feature:
- Macro TX_PILOT_EN.
- Defined:
  - Inside PAYLOAD, after every PILOT_INTERVAL data slots, one pilot slot is inserted with SYM_OUT=4'h5.
  - No pilot follows the final data slot.
  - DATA_READY stays 0 in the cycle preceding a pilot slot.
  - Pilots do not count toward PAYLOAD_LEN.
  - PAYLOAD lasts PAYLOAD_LEN + floor((PAYLOAD_LEN-1)/PILOT_INTERVAL) symbols.
- Not defined: no pilot logic. PILOT_INTERVAL is unused.

Test Plan:
1. Defaults, RESET high for 2 cycles, then a single START pulse with DATA_VALID=1 and an incrementing DATA_IN.
   - First SYM_STB 1 cycle after START.
   - SYM_OUT sequence 0,F,0,F... for 16 symbols, then data 0,1,2..., then 8 muted symbols.
   - FRAME_ACTIVE high exactly 704 cycles, then IDLE.
2. Drop DATA_VALID to 0 on the 10th DATA_READY pulse.
   - Payload symbol 9 = 4'h0; UNDERRUN=1.
   - Total frame length stays 704 cycles.
   - UNDERRUN stays 1 until the next START.
3. CONTINUOUS=1 for 3 frames.
   - No IDLE cycle between frames.
   - SYM_STB period exactly 8 cycles throughout.
   - 2112 active cycles.
4. START asserted during PAYLOAD of frame 1, and again during GUARD.
   - Exactly one extra frame follows back-to-back, then IDLE.
5. RESET asserted mid-PAYLOAD.
   - Next cycle all outputs 0 and IDLE.
   - A START 2 cycles later restarts the preamble at 4'h0.
6. TX_PILOT_EN defined, PILOT_INTERVAL=16.
   - Pilot 4'h5 after data symbols 16, 32 and 48 (3 pilots).
   - No DATA_READY for those slots.
   - Frame length 91 symbols = 728 cycles.
